// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM definitions for the registered ALU unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_ADC = 4'h2,
    OP_SBC = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_NOT = 4'h7,
    OP_INC = 4'h8,
    OP_DEC = 4'h9,
    OP_SHL = 4'hA,
    OP_SHR = 4'hB,
    OP_MUL = 4'hC
  } op_e;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Place the four condition bits at their architectural indices.
  function automatic logic [3:0] make_flags(input logic v, input logic n,
                                            input logic z, input logic c);
    logic [3:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: single-cycle ops only; nop_c marks opcodes that
// must leave result and flags untouched.
module alu_core import alu_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 4
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result_c,
  output logic [3:0]       flags_c,
  output logic             nop_c
);

  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH:0]   sum;
  logic             carry_in;
  logic             arith;
  logic             c_flag;
  logic             v_flag;

  always_comb begin
    opnd_b   = '0;
    carry_in = 1'b0;
    arith    = 1'b0;
    c_flag   = 1'b0;
    v_flag   = 1'b0;
    nop_c    = 1'b0;
    result_c = '0;
    case (op)
      OPW'(OP_ADD): begin opnd_b = b;               arith = 1'b1; end
      OPW'(OP_SUB): begin opnd_b = ~b; carry_in = 1'b1; arith = 1'b1; end
      OPW'(OP_ADC): begin opnd_b = b;  carry_in = cin;  arith = 1'b1; end
      OPW'(OP_SBC): begin opnd_b = ~b; carry_in = cin;  arith = 1'b1; end
      OPW'(OP_INC): begin opnd_b = WIDTH'(1);       arith = 1'b1; end
      OPW'(OP_DEC): begin opnd_b = '1;              arith = 1'b1; end
      OPW'(OP_AND): result_c = a & b;
      OPW'(OP_OR):  result_c = a | b;
      OPW'(OP_XOR): result_c = a ^ b;
      OPW'(OP_NOT): result_c = ~a;
      OPW'(OP_SHL): begin
        result_c = {a[WIDTH-2:0], 1'b0};
        c_flag   = a[WIDTH-1];
      end
      OPW'(OP_SHR): begin
        result_c = {1'b0, a[WIDTH-1:1]};
        c_flag   = a[0];
      end
      default: nop_c = 1'b1;
    endcase

    // Shared adder; V compares sign of a against the effective second operand.
    sum = {1'b0, a} + {1'b0, opnd_b} + (WIDTH+1)'(carry_in);
    if (arith) begin
      result_c = sum[WIDTH-1:0];
      c_flag   = sum[WIDTH];
      v_flag   = (a[WIDTH-1] == opnd_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
    flags_c = make_flags(v_flag, result_c[WIDTH-1], result_c == '0, c_flag);
  end

endmodule

// File: rtl/alu_reg_unit.sv
// Registered ALU with start/busy/done handshake and tri-state bus driver.
// Define ALU_MUL_EN to enable the iterative shift-add multiplier (opcode MUL).
module alu_reg_unit import alu_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  input  logic             start,
  input  logic             out_en,
  output logic             busy,
  output logic             done,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] out
);

  state_e           state;
  logic [WIDTH-1:0] core_result_c;
  logic [3:0]       core_flags_c;
  logic             core_nop_c;

  alu_core #(.WIDTH(WIDTH), .OPW(OPW)) u_core (
    .op       (op),
    .a        (a),
    .b        (b),
    .cin      (flags[FLAG_C]),
    .result_c (core_result_c),
    .flags_c  (core_flags_c),
    .nop_c    (core_nop_c)
  );

  assign out = out_en ? result : 'z;

`ifdef ALU_MUL_EN
  localparam int unsigned CNTW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mul_sum_c;
  logic [WIDTH-1:0]   mplier;
  logic [CNTW-1:0]    cnt;
  logic               busy_q;

  assign mul_sum_c = acc + (mplier[0] ? mcand : '0);
  assign busy      = busy_q;
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      result <= '0;
      flags  <= '0;
      done   <= 1'b0;
`ifdef ALU_MUL_EN
      busy_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
`ifdef ALU_MUL_EN
            if (op == OPW'(OP_MUL)) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= ST_MUL;
            end else
`endif
            begin
              done <= 1'b1;
              if (!core_nop_c) begin
                result <= core_result_c;
                flags  <= core_flags_c;
              end
            end
          end
        end
`ifdef ALU_MUL_EN
        // One partial product per cycle; the last one writes back directly.
        ST_MUL: begin
          acc    <= mul_sum_c;
          mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt + CNTW'(1);
          if (cnt == CNTW'(WIDTH-1)) begin
            result <= mul_sum_c[WIDTH-1:0];
            flags  <= make_flags(1'b0, mul_sum_c[WIDTH-1],
                                 mul_sum_c[WIDTH-1:0] == '0,
                                 |mul_sum_c[2*WIDTH-1:WIDTH]);
            busy_q <= 1'b0;
            done   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_reg_unit.sv
// Bench for alu_reg_unit (WIDTH=8): integer reference model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_alu_reg_unit;
  import alu_pkg::*;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         start;
  logic         out_en;
  logic         busy;
  logic         done;
  logic [3:0]   flags;
  logic [W-1:0] result;
  wire  [W-1:0] bus;

  alu_reg_unit #(.WIDTH(W), .OPW(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .op     (op),
    .start  (start),
    .out_en (out_en),
    .busy   (busy),
    .done   (done),
    .flags  (flags),
    .result (result),
    .out    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= (1 << (W-1))) ? x - (1 << W) : x;
  endfunction

  // Reference behaviour from the arithmetic definitions (true signed overflow).
  function automatic void model_op(input int o, input int x, input int y, input int cin,
                                   inout int r, inout int f);
    int  s, sv;
    bit  ar, c, v;
    ar = 1'b1; c = 1'b0; v = 1'b0; s = 0; sv = 0;
    case (o)
      0:  begin s = x + y;              sv = sx(x) + sx(y); end
      1:  begin s = x + (MASK - y) + 1; sv = sx(x) - sx(y); end
      2:  begin s = x + y + cin;        sv = sx(x) + sx(y) + cin; end
      3:  begin s = x + (MASK - y) + cin; sv = sx(x) - sx(y) - 1 + cin; end
      8:  begin s = x + 1;              sv = sx(x) + 1; end
      9:  begin s = x + MASK;           sv = sx(x) - 1; end
      4:  begin ar = 1'b0; r = x & y; end
      5:  begin ar = 1'b0; r = x | y; end
      6:  begin ar = 1'b0; r = x ^ y; end
      7:  begin ar = 1'b0; r = MASK - x; end
      10: begin ar = 1'b0; r = (x * 2) & MASK; c = (x >> (W-1)) & 1; end
      11: begin ar = 1'b0; r = x / 2; c = x & 1; end
      default: return;
    endcase
    if (ar) begin
      r = s & MASK;
      c = (s >> W) & 1;
      v = (sv > (1 << (W-1)) - 1) || (sv < -(1 << (W-1)));
    end
    f = v * 8 + ((r >> (W-1)) & 1) * 4 + (r == 0) * 2 + c;
  endfunction

  int m_result = 0;
  int m_flags  = 0;
  bit m_busy   = 1'b0;
  bit m_done   = 1'b0;
  int m_rem    = 0;
  int m_ma     = 0;
  int m_mb     = 0;

  always @(posedge clk) begin
    int prod;
    if (reset) begin
      m_result = 0; m_flags = 0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          prod     = m_ma * m_mb;
          m_result = prod & MASK;
          m_flags  = ((m_result >> (W-1)) & 1) * 4 + (m_result == 0) * 2 + ((prod >> W) != 0);
          m_busy   = 1'b0;
          m_done   = 1'b1;
        end
      end else if (start) begin
`ifdef ALU_MUL_EN
        if (int'(op) == 12) begin
          m_busy = 1'b1; m_rem = W; m_ma = int'(a); m_mb = int'(b);
        end else
`endif
        begin
          m_done = 1'b1;
          model_op(int'(op), int'(a), int'(b), m_flags & 1, m_result, m_flags);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("result", 32'(result), 32'(m_result));
      check("flags", 32'(flags), 32'(m_flags));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      if (out_en) check("bus_drive", 32'(bus), 32'(m_result));
      else if (m_result != 0) begin
        n_checks++;
        if (bus === W'(m_result)) begin
          n_fail++;
          $display("FAIL bus_release actual=%0h expected=released @%0t", bus, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
    op = o; a = xa; b = xb; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [3:0]   f;
  } vec_t;

  vec_t tbl[10];
  int   lat;

  initial begin
    tbl[0] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011};
    tbl[1] = '{OP_ADC, 8'h01, 8'h01, 8'h03, 4'b0000};
    tbl[2] = '{OP_ADC, 8'h80, 8'h80, 8'h00, 4'b1011};
    tbl[3] = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    tbl[4] = '{OP_OR,  8'h0F, 8'h80, 8'h8F, 4'b0100};
    tbl[5] = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0010};
    tbl[6] = '{OP_NOT, 8'h0F, 8'h00, 8'hF0, 4'b0100};
    tbl[7] = '{OP_INC, 8'h7F, 8'h00, 8'h80, 4'b1100};
    tbl[8] = '{OP_DEC, 8'h00, 8'h00, 8'hFF, 4'b0100};
    tbl[9] = '{OP_SBC, 8'h00, 8'h01, 8'hFE, 4'b0100};

    reset = 1'b1; start = 1'b0; out_en = 1'b0; op = '0; a = '0; b = '0;
    tick(); tick();
    check("rst_result", 32'(result), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    chk_en = 1'b1;
    reset  = 1'b0;
    out_en = 1'b1;
    tick();
    check("bus_after_rst", 32'(bus), 32'h0);

    issue(OP_ADD, 8'h7F, 8'h01);
    check("add_res", 32'(result), 32'h80);
    check("add_flags", 32'(flags), 32'b1100);
    check("add_done", 32'(done), 32'h1);
    tick();
    check("add_done_drop", 32'(done), 32'h0);

    issue(OP_SUB, 8'h05, 8'h05);
    check("sub_res", 32'(result), 32'h00);
    check("sub_flags", 32'(flags), 32'b0011);
    issue(OP_SBC, 8'h10, 8'h01);
    check("sbc_res", 32'(result), 32'h0F);
    check("sbc_flags", 32'(flags), 32'b0001);

    issue(OP_SHL, 8'h81, 8'h00);
    check("shl_res", 32'(result), 32'h02);
    check("shl_flags", 32'(flags), 32'b0001);
    issue(OP_SHR, 8'h01, 8'h00);
    check("shr_res", 32'(result), 32'h00);
    check("shr_flags", 32'(flags), 32'b0011);
    issue(4'hE, 8'h55, 8'h66);
    check("rsv_res", 32'(result), 32'h00);
    check("rsv_flags", 32'(flags), 32'b0011);
    check("rsv_done", 32'(done), 32'h1);

    // Back-to-back with start held; ADC/SBC chain on the previous carry.
    out_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; start = 1'b1;
      tick();
      check($sformatf("b2b_res_%0d", i), 32'(result), 32'(tbl[i].r));
      check($sformatf("b2b_flags_%0d", i), 32'(flags), 32'(tbl[i].f));
      check($sformatf("b2b_done_%0d", i), 32'(done), 32'h1);
    end
    start  = 1'b0;
    out_en = 1'b1;
    tick();

`ifdef ALU_MUL_EN
    issue(OP_MUL, 8'h10, 8'h20);
    check("mul_busy", 32'(busy), 32'h1);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (lat == 3) begin op = OP_ADD; a = 8'h01; b = 8'h01; start = 1'b1; end
      else start = 1'b0;
      tick();
      lat++;
    end
    start = 1'b0;
    check("mul_latency", 32'(lat), 32'(W));
    check("mul_res", 32'(result), 32'h00);
    check("mul_flags", 32'(flags), 32'b0011);
    check("mul_busy_end", 32'(busy), 32'h0);
    tick();
`else
    issue(OP_MUL, 8'h10, 8'h20);
    check("mulnop_res", 32'(result), 32'hFE);
    check("mulnop_flags", 32'(flags), 32'b0100);
    check("mulnop_done", 32'(done), 32'h1);
    check("mulnop_busy", 32'(busy), 32'h0);
    tick();
`endif

    // Reset in the middle of a (possibly multi-cycle) operation.
    issue(OP_MUL, 8'h0F, 8'h0F);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_result", 32'(result), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    for (int i = 0; i < 10; i++) tick();
    issue(OP_ADD, 8'h02, 8'h03);
    check("post_abort_res", 32'(result), 32'h05);
    check("post_abort_done", 32'(done), 32'h1);
    tick(); tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_reg_unit.md
Name: alu_reg_unit

Overview:
- Parametrised successor to the 8-bit add/sub ALU with tri-state bus driver.
- Adds a registered result latch, a registered flag register (C/Z/N/V), an extended opcode set and a start/busy/done handshake.
- Sits between the A/B registers and the shared data bus; the controller issues `start`, then asserts `out_en` to drive the latched result onto the bus.
- An optional iterative multiplier makes the handshake genuinely multi-cycle.

Parameters:
- WIDTH, 8, datapath width in bits (min 4).
- OPW, 4, opcode width in bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  OPW  operation select, sampled with start
- start  in  1  request; accepted only when busy=0
- out_en  in  1  drive result onto out when 1
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse when result/flags update
- flags  out  4  registered {V,N,Z,C}
- result  out  WIDTH  registered result, always visible
- out  out  WIDTH  tri-state bus: result when out_en=1, else high-Z

Behaviour:
- Reset (sync, reset=1 at edge): result=0, flags=0, busy=0, done=0, FSM→IDLE. Reset during MUL aborts the operation with no done pulse.
- out is combinational from result and out_en. It is high-Z during and after reset unless out_en=1.
- FSM states: IDLE, MUL.
  - IDLE + start + single-cycle op: result/flags update at that edge; done=1 for the following cycle.
  - IDLE + start + MUL: latch a/b, busy=1, enter MUL.
- start while busy=1 is ignored (no queueing). done is never asserted while busy=1.
- Arithmetic is WIDTH+1 bits. C is the carry-out of bit WIDTH-1.
  - ADD: a+b.
  - SUB: a+~b+1; C=1 means no borrow.
  - ADC: a+b+C_q.
  - SBC: a+~b+C_q.
  - INC: a+1.
  - DEC: a+all-ones.
- V = signed overflow: (a_msb==b'_msb) && (r_msb!=a_msb), where b' is the effective second operand.
- AND/OR/XOR/NOT(a): C=0, V=0.
- SHL(a): C=a[WIDTH-1], lsb=0, V=0.
- SHR(a): logical; C=a[0], msb=0, V=0.
- Z = (result==0). N = result[WIDTH-1]. Both are computed on the new result for every op.
- Reserved opcodes are NOP: result and flags held, done still pulses.
- Back-to-back single-cycle ops: start may be held high; one op completes per cycle, with done high each following cycle. ADC/SBC use the C flag registered by the previous op.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL opcode runs unsigned shift-add over WIDTH cycles in state MUL.
  - busy=1 from the cycle after acceptance until completion.
  - At completion: result = low WIDTH bits of product; C=1 iff the high half is nonzero; V=0; Z/N from result; busy→0; done pulses; FSM→IDLE.
  - Total latency from the start edge to done high: WIDTH+1 cycles.
- Undefined: MUL is a reserved NOP. busy is tied 0. FSM is IDLE only.

Decomposition:
- Package alu_pkg holds:
  - Opcode constants: ADD=0, SUB=1, ADC=2, SBC=3, AND=4, OR=5, XOR=6, NOT=7, INC=8, DEC=9, SHL=A, SHR=B, MUL=C, D–F reserved.
  - Flag bit indices: C=0, Z=1, N=2, V=3.
  - FSM state encoding.
- Sub-module alu_core: purely combinational; op/a/b/cin in, result/flags out.
- The top holds the registers, FSM, multiplier iteration and tri-state driver.

Test Plan (WIDTH=8):
- reset=1 with out_en=0 → result=0x00, flags=0, busy=0, out=Z. Then out_en=1 → out=0x00.
- ADD a=0x7F, b=0x01 → result=0x80, N=1, V=1, C=0, Z=0; done high exactly one cycle.
- SUB a=0x05, b=0x05 → 0x00, Z=1, C=1. Then SBC a=0x10, b=0x01 → 0x0F, C=1.
- SHL a=0x81 → 0x02, C=1. SHR a=0x01 → 0x00, Z=1, C=1. Reserved op 0xE → result and flags unchanged, done pulses.
- ALU_MUL_EN, MUL a=0x10, b=0x20 → busy for 8 cycles; result=0x00, C=1, Z=1; done at cycle 9. A second start mid-op is ignored.
- MUL a=0x0F, b=0x0F with reset asserted at cycle 4 → busy=0, result=0, no done. Then ADD accepted normally.
